master_bridge_fifo_wr_arbiter: RTL
==================================

// Module: master_bridge_fifo_wr_arbiter
// PURPOSE
//  Write-side scheduler for the master-bridge async FIFO; lives in the W_CLK domain.
//  Shares the single FIFO write port between NUM_REQ packet sources (e.g. posted,
//  non-posted and completion TLP paths) using round-robin arbitration.
//  A grant is held for a whole packet (until req_last), so beats from different
//  sources never interleave. Drives wr_inc/wr_data and honours wr_full backpressure.
// PARAMETERS
//  NUM_REQ     4    number of requesters (>=2)
//  DATA_WIDTH  64   width of one FIFO entry / beat
//  IDW         2    grant index width, must equal clog2(NUM_REQ)
// PORTS
//  W_CLK      in   1                   write-domain clock
//  W_RST      in   1                   synchronous, active-high reset
//  req_valid  in   NUM_REQ             per-source beat valid
//  req_last   in   NUM_REQ             per-source last beat of packet
//  req_data   in   NUM_REQ*DATA_WIDTH  per-source beat; source i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready  out  NUM_REQ             per-source beat accepted this cycle
//  wr_full    in   1                   FIFO full, from the FIFO write-pointer logic
//  wr_inc     out  1                   FIFO write strobe
//  wr_data    out  DATA_WIDTH          FIFO write data
//  gnt_id     out  IDW                 index of the current or most recent grant
//  busy       out  1                   packet transfer in progress
// BEHAVIOUR
//  - Reset (W_RST=1 at a W_CLK edge): state=IDLE, gnt_id=0, rr_ptr=NUM_REQ-1, busy=0.
//    Reset forces req_ready=0 and wr_inc=0 combinationally. With the rr_ptr reset
//    value above, requester 0 has first priority.
//  - Mid-packet reset abandons the packet. No FIFO write occurs in the reset cycle.
//  - FSM IDLE:
//    * If no req_valid bit is set, stay in IDLE.
//    * Otherwise choose the first set req_valid bit, scanning upward from rr_ptr+1
//      modulo NUM_REQ.
//    * Register the winner into gnt_id, set rr_ptr=winner, set busy=1, go to XFER.
//    * req_ready is all-zero in IDLE. Arbitration latency is 1 cycle: the first beat
//      can transfer in the cycle after the request is seen.
//  - FSM XFER, with g = gnt_id:
//    * req_ready[g] = ~wr_full; all other req_ready bits are 0.
//    * wr_inc = req_valid[g] & ~wr_full.
//    * wr_data = req_data slice g, combinational mux; it is don't-care when wr_inc=0.
//    * A beat transfers when wr_inc=1.
//    * On a beat that transfers with req_last[g]=1: busy=0 and the FSM returns to IDLE.
//      This costs one bubble cycle before the next grant.
//    * req_valid[g]=0 mid-packet: hold the grant and wait; other sources stay blocked.
//  - wr_full=1: no beat transfers and the grant is held. Transfer resumes in the first
//    cycle with wr_full=0. wr_inc is never asserted while wr_full=1.
//  - Simultaneous requests are resolved strictly by round-robin order. A source that
//    has just been served is last in line for the next arbitration.
//  - gnt_id keeps its value in IDLE until the next grant.
// CONFIGURATION
//  MB_WR_ARB_PRIO_EN defined:
//    * Requester 0 is high priority: if req_valid[0]=1 in IDLE, it wins regardless
//      of rr_ptr.
//    * Requesters 1..NUM_REQ-1 round-robin among themselves. rr_ptr is updated only
//      by grants to those requesters.
//    * Requester 0 never preempts a packet already in progress.
//  MB_WR_ARB_PRIO_EN undefined: pure round-robin over all NUM_REQ sources.
// TESTING
//  1. Out of reset, req_valid=4'b1111 with 1-beat packets -> grants in order 0,1,2,3,0.
//     One wr_inc every 2 cycles.
//  2. Src2 sends a 3-beat packet while src1 raises valid mid-packet -> FIFO receives
//     src2 beats D0,D1,D2 contiguously, then src1. No interleave.
//  3. wr_full=1 for 5 cycles in the middle of a 4-beat packet -> wr_inc=0 and
//     req_ready=0 during the stall. All 4 beats are written exactly once, in order.
//  4. W_RST=1 after beat 2 of a 4-beat packet -> next cycle state=IDLE, busy=0,
//     gnt_id=0. The next grant goes to src0 if it is valid.
//  5. Granted source drops req_valid for 3 cycles mid-packet -> wr_inc=0, grant held,
//     other sources get no req_ready.
//  6. With MB_WR_ARB_PRIO_EN and req_valid=4'b1110 then src0 rising -> src0 wins at
//     the next IDLE arbitration. The rest rotate 1,2,3.

Source files
------------

// File: rtl/master_bridge_fifo_wr_arbiter_if.sv
// Bundle between packet sources, the write arbiter and the async FIFO write port.
// The master modport is the arbiter side; the slave modport is the sources/FIFO side.
interface master_bridge_fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IDW        = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wr_full;
  logic                          wr_inc;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [IDW-1:0]                gnt_id;
  logic                          busy;

  modport master (
    input  req_valid, req_last, req_data, wr_full,
    output req_ready, wr_inc, wr_data, gnt_id, busy
  );

  modport slave (
    output req_valid, req_last, req_data, wr_full,
    input  req_ready, wr_inc, wr_data, gnt_id, busy
  );
endinterface

// File: rtl/master_bridge_fifo_wr_arbiter.sv
// Packet-granular round-robin scheduler for the master-bridge async FIFO write port.
// Optional MB_WR_ARB_PRIO_EN: requester 0 wins every IDLE arbitration it requests.
module master_bridge_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int IDW        = 2
) (
  input  logic                           W_CLK,
  input  logic                           W_RST,
  master_bridge_fifo_wr_arbiter_if.master bus
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDW-1:0]       gnt_id_q;
  logic [IDW-1:0]       rr_ptr;
  logic                 busy_q;
  logic [IDW-1:0]       winner;
  logic [IDW-1:0]       idx;
  logic                 found;
  logic                 sel_valid;
  logic                 sel_last;
  logic [NUM_REQ-1:0]   req_ready_c;
  logic                 wr_inc_c;
  logic [DATA_WIDTH-1:0] wr_data_c;

  // Arbitration: scan upward from the slot after the last winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = rr_ptr;
`ifdef MB_WR_ARB_PRIO_EN
    if (bus.req_valid[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 1; k < NUM_REQ; k++) begin
        idx = (idx >= IDW'(NUM_REQ-1) || idx == '0) ? IDW'(1) : idx + IDW'(1);
        if (!found && bus.req_valid[idx]) begin
          winner = idx;
          found  = 1'b1;
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == IDW'(NUM_REQ-1)) ? '0 : idx + IDW'(1);
      if (!found && bus.req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge W_CLK) begin
    if (W_RST) begin
      state    <= IDLE;
      gnt_id_q <= '0;
      rr_ptr   <= IDW'(NUM_REQ-1);
      busy_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        gnt_id_q <= winner;
        busy_q   <= 1'b1;
`ifdef MB_WR_ARB_PRIO_EN
        if (winner != '0) rr_ptr <= winner;
`else
        rr_ptr <= winner;
`endif
      end else if (state == XFER && wr_inc_c && sel_last) begin
        busy_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = XFER;
      XFER:    if (wr_inc_c && sel_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: the granted source is muxed straight onto the FIFO write port.
  always_comb begin
    req_ready_c = '0;
    wr_inc_c    = 1'b0;
    wr_data_c   = '0;
    sel_valid   = 1'b0;
    sel_last    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id_q == IDW'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        wr_data_c = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (state == XFER && !W_RST) begin
      for (int i = 0; i < NUM_REQ; i++)
        req_ready_c[i] = (gnt_id_q == IDW'(i)) && !bus.wr_full;
      wr_inc_c = sel_valid && !bus.wr_full;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.wr_inc    = wr_inc_c;
  assign bus.wr_data   = wr_data_c;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.busy      = busy_q;

endmodule
